// File: rtl/inv_key_sched.sv
// Iterative AES-128 inverse key scheduler: walks round key 10 back to round 0,
// one key per clock, and keeps all 11 keys in a readable table.

module sbox (
  input  logic [7:0] a,
  output logic [7:0] c
);

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) begin
        p = p ^ t;
      end else begin
        p = p;
      end
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254; zero maps to zero naturally
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240;
    x2   = gmul(x, x);
    x3   = gmul(x2, x);
    x6   = gmul(x3, x3);
    x12  = gmul(x6, x6);
    x15  = gmul(x12, x3);
    x30  = gmul(x15, x15);
    x60  = gmul(x30, x30);
    x120 = gmul(x60, x60);
    x240 = gmul(x120, x120);
    return gmul(gmul(x240, x12), x2);
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  logic [7:0] b_s;

  // Inverse followed by the AES affine transform
  always_comb begin
    b_s = ginv(a);
    c   = b_s ^ rotl(b_s, 1) ^ rotl(b_s, 2) ^ rotl(b_s, 3) ^ rotl(b_s, 4) ^ 8'h63;
  end

endmodule

module inv_key_sched (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         key_valid,
  output logic [3:0]   round_out,
  output logic [127:0] key_out,
  output logic         done,
  output logic         table_valid,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key
);

  typedef enum logic [0:0] {IDLE = 1'b0, GEN = 1'b1} state_t;

  state_t         state_r, state_s;
  logic [127:0]   work_r;
  logic [3:0]     cnt_r;
  logic [127:0]   tbl_r [0:10];
  logic           done_r;
  logic           table_valid_r;

  logic [31:0]    w0_s, w1_s, w2_s, w3_s;
  logic [31:0]    p0_s, p1_s, p2_s, p3_s;
  logic [31:0]    rot_s, sub_s;
  logic [127:0]   prev_s;
  logic [127:0]   rd_key_s;

  // rcon for the key being recovered (round r-1), indexed by the current round r
  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Undo the forward XOR chain, then recover w0 through SubWord(RotWord(w3 of round r-1))
  always_comb begin
    w0_s  = work_r[127:96];
    w1_s  = work_r[95:64];
    w2_s  = work_r[63:32];
    w3_s  = work_r[31:0];
    p3_s  = w3_s ^ w2_s;
    p2_s  = w2_s ^ w1_s;
    p1_s  = w1_s ^ w0_s;
    rot_s = {p3_s[23:0], p3_s[31:24]};
  end

  genvar g;
  for (g = 0; g < 4; g++) begin : g_sbox
    sbox u_sbox (.a(rot_s[8*g +: 8]), .c(sub_s[8*g +: 8]));
  end

  // Assemble the previous round key
  always_comb begin
    p0_s   = w0_s ^ sub_s ^ {rcon(cnt_r), 24'h000000};
    prev_s = {p0_s, p1_s, p2_s, p3_s};
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = GEN;
        end else begin
          state_s = IDLE;
        end
      end
      GEN: begin
        if (cnt_r == 4'd0) begin
          state_s = IDLE;
        end else begin
          state_s = GEN;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Working key, round counter, key table and completion flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_r        <= 128'h0;
      cnt_r         <= 4'd0;
      done_r        <= 1'b0;
      table_valid_r <= 1'b0;
      for (int i = 0; i < 11; i++) begin
        tbl_r[i] <= 128'h0;
      end
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            work_r        <= key_in;
            cnt_r         <= 4'd10;
            table_valid_r <= 1'b0;
          end
        end
        GEN: begin
          tbl_r[cnt_r] <= work_r;
          if (cnt_r == 4'd0) begin
            // work_r is left holding round 0 so key_out stays meaningful
            done_r        <= 1'b1;
            table_valid_r <= 1'b1;
          end else begin
            work_r <= prev_s;
            cnt_r  <= cnt_r - 4'd1;
          end
        end
        default: begin
          done_r <= 1'b0;
        end
      endcase
    end
  end

  // Unregistered table read, masked until the whole table is coherent
  always_comb begin
    rd_key_s = 128'h0;
    if (table_valid_r && (rd_idx <= 4'd10)) begin
      rd_key_s = tbl_r[rd_idx];
    end else begin
      rd_key_s = 128'h0;
    end
  end

  assign busy        = (state_r == GEN);
  assign key_valid   = (state_r == GEN);
  assign round_out   = (state_r == GEN) ? cnt_r : 4'd0;
  assign key_out     = work_r;
  assign done        = done_r;
  assign table_valid = table_valid_r;
  assign rd_key      = rd_key_s;

endmodule
